keypad_scan: RTL

Scanner for the 4x4 matrix keypad. Drives the column lines, samples the row lines, debounces whole-matrix frames and presents the debounced key as a 16-bit one-hot code. Its output feeds the one-hot-to-binary key encoder, which holds its binary value while `onehot` is unchanged, so `onehot` holds the last reported key.

---
 rtl/keypad_scan_if.sv | 25 ++
 rtl/keypad_scan.sv | 130 +++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Signal bundle between the 4x4 keypad scanner and its surroundings.
// The slave modport is the scanner's view; master is the keypad/consumer side.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_down;

    modport slave (
        input  row,
        output col,
        output onehot,
        output key_valid,
        output key_down
    );

    modport master (
        output row,
        input  col,
        input  onehot,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, whole-frame
// debounce and one-hot key reporting (bit = 4*column + row).
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 3
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.slave  kp
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

    // True when exactly one bit of the frame is set.
    function automatic logic is_single_key(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

    logic [3:0]    row_s1_q, row_s1_d;
    logic [3:0]    row_s2_q, row_s2_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [3:0]    col_q, col_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   prev_q, prev_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [15:0]   onehot_q, onehot_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          tick_s;
    logic [15:0]   samp_s;
    logic [15:0]   frame_full_s;

    // Next-state logic: prescaler, column stepping, frame accumulation, debounce.
    always_comb begin
        row_s1_d     = kp.row;
        row_s2_d     = row_s1_q;
        div_d        = div_q;
        cidx_d       = cidx_q;
        col_d        = col_q;
        frame_d      = frame_q;
        prev_d       = prev_q;
        stable_d     = stable_q;
        onehot_d     = onehot_q;
        key_valid_d  = 1'b0;
        key_down_d   = key_down_q;

        tick_s       = (div_q == DIV_LAST);
        // Pressed rows of the current column land at bits 4*cidx..4*cidx+3.
        samp_s       = {12'h000, ~row_s2_q} << {cidx_q, 2'b00};
        frame_full_s = frame_q | samp_s;

        if (tick_s) begin
            div_d  = '0;
            cidx_d = cidx_q + 2'd1;
            col_d  = ~(4'b0001 << cidx_d);
            if (cidx_q == 2'd3) begin
                frame_d = 16'h0000;
                prev_d  = frame_full_s;
                if (frame_full_s == prev_q) begin
                    stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
                end else begin
                    stable_d = SW'(1);
                end

                // Only a frame that has been stable long enough may change the outputs.
                if (stable_d == STABLE_MAX) begin
                    if (is_single_key(frame_full_s)) begin
                        if (!key_down_q || (frame_full_s != onehot_q)) begin
                            onehot_d    = frame_full_s;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                        end else begin
                            onehot_d    = onehot_q;
                        end
                    end else if (frame_full_s == 16'h0000) begin
                        key_down_d = 1'b0;
                    end else begin
                        key_down_d = key_down_q;
                    end
                end else begin
                    key_down_d = key_down_q;
                end
            end else begin
                frame_d = frame_full_s;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            div_q       <= '0;
            cidx_q      <= 2'd0;
            col_q       <= 4'b1110;
            frame_q     <= 16'h0000;
            prev_q      <= 16'h0000;
            stable_q    <= '0;
            onehot_q    <= 16'h0000;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            div_q       <= div_d;
            cidx_q      <= cidx_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.onehot    = onehot_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

endmodule
